// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU and response signals of the sequencer
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_op;
    logic        flush;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_err;
    modport master (
        output req_valid, req_a, req_b, req_op, flush, rsp_ready, alu_result,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, flush, rsp_ready, alu_result,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: IDLE/EXEC/DONE sequencer for a combinational ALU with per-op latency.
// Define ALU_SEQ_DIV0_TRAP_EN to turn divide-by-zero into an immediate error response.
module alu_op_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input logic clk,
    input logic reset_n,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t     state;
    logic [5:0] cnt;
    logic [5:0] lat;
    logic       trap;
    always_comb lat = bus.req_op == 4'd4 ? 6'(MUL_LAT - 1) : bus.req_op == 4'd5 ? 6'(DIV_LAT - 1) : 6'd0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    always_comb trap = bus.req_op >= 4'd13 || (bus.req_op == 4'd5 && bus.req_b == 32'd0);
`else
    always_comb trap = bus.req_op >= 4'd13;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_hi    <= '0;
            bus.rsp_lo    <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
        end else if (bus.flush) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.alu_a     <= bus.req_a;
                    bus.alu_b     <= bus.req_b;
                    bus.alu_op    <= bus.req_op;
                    bus.req_ready <= 1'b0;
                    if (trap) begin
                        state         <= DONE;
                        bus.rsp_hi    <= '0;
                        bus.rsp_lo    <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        state <= EXEC;
                        cnt   <= lat;
                    end
                end
                EXEC: if (cnt == 6'd0) begin
                    state         <= DONE;
                    bus.rsp_hi    <= bus.alu_result[63:32];
                    bus.rsp_lo    <= bus.alu_result[31:0];
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 6'd1;
                end
                DONE: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of latency, handshakes, error ops, flush and reset.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    logic seen;
    alu_op_sequencer_if bus();
    alu_op_sequencer #(.MUL_LAT(4), .DIV_LAT(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    // Reference ALU: the combinational unit the sequencer drives
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            4'd0: bus.alu_result = {32'd0, bus.alu_a & bus.alu_b};
            4'd1: bus.alu_result = {32'd0, bus.alu_a | bus.alu_b};
            4'd2: bus.alu_result = {32'd0, bus.alu_a + bus.alu_b};
            4'd3: bus.alu_result = {32'd0, bus.alu_a - bus.alu_b};
            4'd4: bus.alu_result = {{32{bus.alu_a[31]}}, bus.alu_a} * {{32{bus.alu_b[31]}}, bus.alu_b};
            4'd5: bus.alu_result = bus.alu_b == 32'd0 ? 64'd0 : {bus.alu_a % bus.alu_b, bus.alu_a / bus.alu_b};
            4'd6: bus.alu_result = {32'd0, bus.alu_a >> bus.alu_b[4:0]};
            4'd7: bus.alu_result = {32'd0, 32'($signed(bus.alu_a) >>> bus.alu_b[4:0])};
            4'd8: bus.alu_result = {32'd0, bus.alu_a << bus.alu_b[4:0]};
            4'd11: bus.alu_result = {32'd0, -bus.alu_a};
            4'd12: bus.alu_result = {32'd0, ~bus.alu_a};
            default: bus.alu_result = '0;
        endcase
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        check("rst_err", 64'(bus.rsp_err), 64'd0);
        check("rst_alu", {bus.alu_a, bus.alu_b}, 64'd0);
        // add
        issue(32'd5, 32'd7, 4'd2);
        check("add_busy", 64'(bus.req_ready), 64'd0);
        check("add_alu_op", 64'(bus.alu_op), 64'd2);
        wait_rsp(cyc);
        check("add_lat", 64'(cyc), 64'd1);
        check("add_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd12);
        check("add_err", 64'(bus.rsp_err), 64'd0);
        @(posedge clk);
        #1;
        check("add_ready", 64'(bus.req_ready), 64'd1);
        // multiply: req_ready low for MUL_LAT + 1 cycles
        issue(-32'sd3, 32'd6, 4'd4);
        cyc = 0;
        while (!bus.req_ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mul_busy_cycles", 64'(cyc), 64'd5);
        check("mul_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'hFFFFFFFF_FFFFFFEE);
        // divide with back-pressure
        bus.rsp_ready = 1'b0;
        issue(32'd17, 32'd5, 4'd5);
        wait_rsp(cyc);
        check("div_lat", 64'(cyc), 64'd32);
        check("div_rsp", {bus.rsp_hi, bus.rsp_lo}, {32'd2, 32'd3});
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd2;
        seen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            seen &= bus.rsp_valid && bus.rsp_hi == 32'd2 && bus.rsp_lo == 32'd3 && !bus.rsp_err && !bus.req_ready;
        end
        check("div_hold", 64'(seen), 64'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("div_release_valid", 64'(bus.rsp_valid), 64'd0);
        check("div_release_ready", 64'(bus.req_ready), 64'd1);
        check("div_no_same_edge", 64'(bus.alu_op), 64'd5);
        // divide by zero
        issue(32'd8, 32'd0, 4'd5);
        wait_rsp(cyc);
`ifdef ALU_SEQ_DIV0_TRAP_EN
        check("div0_lat", 64'(cyc), 64'd0);
        check("div0_err", 64'(bus.rsp_err), 64'd1);
        check("div0_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
`else
        check("div0_lat", 64'(cyc), 64'd32);
        check("div0_err", 64'(bus.rsp_err), 64'd0);
`endif
        @(posedge clk);
        #1;
        // illegal opcode
        issue(32'd1, 32'd2, 4'd14);
        wait_rsp(cyc);
        check("op14_lat", 64'(cyc), 64'd0);
        check("op14_err", 64'(bus.rsp_err), 64'd1);
        check("op14_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        @(posedge clk);
        #1;
        // flush three cycles into a divide
        issue(32'd100, 32'd7, 4'd5);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_ready", 64'(bus.req_ready), 64'd1);
        check("flush_valid", 64'(bus.rsp_valid), 64'd0);
        check("flush_keep_err", 64'(bus.rsp_err), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= bus.rsp_valid;
        end
        check("flush_no_rsp", 64'(seen), 64'd0);
        issue(32'd1, 32'd1, 4'd2);
        wait_rsp(cyc);
        check("post_flush_lat", 64'(cyc), 64'd1);
        check("post_flush_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd2);
        @(posedge clk);
        #1;
        // reset mid-multiply
        issue(-32'sd3, 32'd6, 4'd4);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_rsp", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        check("arst_alu", {bus.alu_a, 28'd0, bus.alu_op}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_ready", 64'(bus.req_ready), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen |= bus.rsp_valid;
        end
        check("arst_no_stale", 64'(seen), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
